pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline stage register that replaces the fixed per-stage registers between IF/ID/EX/MEM/WB. Carries a control field and a data field with a valid/ready handshake, synchronous flush (bubble insertion), an optional 2-entry skid buffer that breaks the combinational ready path, and a saturating stall counter. One instance sits between each pair of pipeline stages.

Parameters:
DATA_W, 64, width of the data field (PC+4, operands, immediates, register numbers, concatenated).
CTRL_W, 9, width of the control field (EX/MEM/WB control bits, concatenated).
CTRL_BUBBLE, 0, control value driven whenever the stage holds no valid entry (NOP: RegWrite=0, MWrite=0, Branch=0).
SKID, 1, 0 = single register with combinational ready; 1 = main + skid register with registered ready.
CNT_W, 16, width of the stall counter.

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  discard all held entries and any input offered this cycle
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
in_ctrl  in  CTRL_W  upstream control field
in_data  in  DATA_W  upstream data field
out_valid  out  1  downstream entry valid
out_ready  in  1  downstream accepts entry (0 = stall)
out_ctrl  out  CTRL_W  control field; CTRL_BUBBLE when out_valid=0
out_data  out  DATA_W  data field; holds last value when out_valid=0
occupancy  out  2  entries held (0..1 for SKID=0, 0..2 for SKID=1)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rst=1 at edge): out_valid=0, occupancy=0, out_data=0, out_ctrl=CTRL_BUBBLE, stall_cnt=0, skid entry invalid. Reset overrides flush and all transfers.
- Latency: 1 cycle; an entry accepted at edge N is on out_* after edge N when the stage was empty or draining.
- out_ctrl is CTRL_BUBBLE whenever out_valid=0, independent of stored contents.
- SKID=0: states EMPTY, ONE. in_ready = ~flush & (~out_valid | out_ready), combinational from out_ready. EMPTY+in_fire -> ONE. ONE+out_fire+in_fire -> ONE with new entry. ONE+out_fire only -> EMPTY. ONE without out_fire -> hold, entry unchanged.
- SKID=1: states EMPTY, ONE (main), FULL (main+skid). Output always from main. in_ready = ~flush & (state != FULL), derived from registers only, no path from out_ready.
  EMPTY+in_fire -> ONE.
  ONE: in_fire & out_fire -> ONE with main<=in. in_fire only -> FULL with skid<=in. out_fire only -> EMPTY.
  FULL: out_fire -> ONE with main<=skid. No input can arrive because in_ready=0.
- Order is preserved and entries are never duplicated or dropped, except by flush.
- Flush (flush=1 at edge, rst=0): next state EMPTY, occupancy=0, out_valid=0. Any input offered that cycle is not accepted because in_ready=0. Data registers may keep stale contents; out_ctrl=CTRL_BUBBLE.
- Flush and stall in the same cycle: flush wins. stall_cnt still increments for that cycle if out_valid & ~out_ready.
- stall_cnt: +1 per cycle with out_valid & ~out_ready. Saturates at 2^CNT_W-1. Cleared only by rst.
- Illegal parameter (SKID not 0/1) is an elaboration error.

Decomposition:
- Shared package pipe_pkg: state encoding (ST_EMPTY, ST_ONE, ST_FULL), per-boundary CTRL_W/DATA_W constants, field offsets for RegWrite, MemtoReg, Branch, MRead, MWrite, ALUSrc, ALUOp, RegDst, and the NOP bubble constant.
- Single module; no sub-module. The skid slot is a generate branch on SKID.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, in_ctrl=9'h1FF -> out_valid=0, out_ctrl=0, occupancy=0, stall_cnt=0; first entry appears 1 cycle after release.
- Streaming, SKID=1, out_ready=1: send data 1..8 back-to-back -> out_data 1..8 in order, one per cycle, 1-cycle latency, in_ready constant 1.
- Backpressure, SKID=1: out_ready=0 for 3 cycles while sending A, B, C -> A held on output, B in skid, in_ready=0 after 2 entries, C held upstream, stall_cnt=3. Release -> A, B, C emerge on consecutive cycles.
- SKID=0 same stall -> in_ready tracks out_ready combinationally, occupancy ≤1, no entry lost.
- Flush while FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0. Offered entry is absent from the output, and the next entry flows normally.
- Saturation, CNT_W=4: hold out_ready=0 for 20 cycles with a valid entry -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy state encoding,
// per-boundary field widths, control-bit offsets and the NOP bubble value.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // Per-boundary field widths; ID/EX carries the full 9-bit control word.
    localparam int unsigned IF_ID_CTRL_W  = 1;
    localparam int unsigned IF_ID_DATA_W  = 64;
    localparam int unsigned ID_EX_CTRL_W  = 9;
    localparam int unsigned ID_EX_DATA_W  = 64;
    localparam int unsigned EX_MEM_CTRL_W = 5;
    localparam int unsigned EX_MEM_DATA_W = 64;
    localparam int unsigned MEM_WB_CTRL_W = 2;
    localparam int unsigned MEM_WB_DATA_W = 64;

    localparam int unsigned CTRL_REGDST_BIT   = 0;
    localparam int unsigned CTRL_ALUOP_LSB    = 1;
    localparam int unsigned CTRL_ALUOP_W      = 2;
    localparam int unsigned CTRL_ALUSRC_BIT   = 3;
    localparam int unsigned CTRL_MWRITE_BIT   = 4;
    localparam int unsigned CTRL_MREAD_BIT    = 5;
    localparam int unsigned CTRL_BRANCH_BIT   = 6;
    localparam int unsigned CTRL_MEMTOREG_BIT = 7;
    localparam int unsigned CTRL_REGWRITE_BIT = 8;

    // RegWrite, MWrite and Branch all clear: the stage has no architectural effect.
    localparam logic [8:0] CTRL_NOP = 9'h000;

    function automatic logic [1:0] state_occupancy(stage_state_e s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush,
// optional 2-entry skid buffer and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = 64,
    parameter int unsigned       CTRL_W      = 9,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_NOP),
    parameter int unsigned       SKID        = 1,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      r_state;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_valid;
    logic              w_out_fire;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

    generate
        if (SKID == 1) begin : g_skid
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;

            // Ready depends on registered state only, cutting the out_ready -> in_ready path.
            assign w_in_ready = ~flush & (r_state != ST_FULL);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                end else if (!flush && r_state == ST_ONE && w_in_fire && !w_out_fire) begin
                    r_skid_ctrl <= in_ctrl;
                    r_skid_data <= in_data;
                end
            end

            assign w_skid_ctrl = r_skid_ctrl;
            assign w_skid_data = r_skid_data;
        end else if (SKID == 0) begin : g_noskid
            assign w_in_ready  = ~flush & (~w_out_valid | out_ready);
            assign w_skid_ctrl = '0;
            assign w_skid_data = '0;
        end else begin : g_bad_skid
            $error("pipe_stage_reg: SKID must be 0 or 1");
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_ctrl  <= CTRL_BUBBLE;
            r_data  <= '0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_state <= ST_ONE;
                        r_ctrl  <= in_ctrl;
                        r_data  <= in_data;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_ctrl <= in_ctrl;
                        r_data <= in_data;
                    end else if (w_in_fire) begin
                        // Only reachable with a skid slot; without one in_ready implies out_ready.
                        r_state <= ST_FULL;
                    end else if (w_out_fire) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_state <= ST_ONE;
                        r_ctrl  <= w_skid_ctrl;
                        r_data  <= w_skid_data;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready && r_stall_cnt != {CNT_W{1'b1}}) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_ctrl  = w_out_valid ? r_ctrl : CTRL_BUBBLE;
    assign out_data  = r_data;
    assign occupancy = state_occupancy(r_state);
    assign stall_cnt = r_stall_cnt;

endmodule
